// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier controller.
// Holds the FSM state enum, datapath control-word bit indices and widths.
// Optional build macro used by importers: BOOTH_FAST_SHIFT_EN.
package booth_pkg;

    localparam int DATA_W = 8;
    localparam int CTL_W  = 11;
    localparam int CNT_W  = 3;

    // Datapath control-word bit positions
    localparam int CTL_LD_A  = 0;   // A <= adder output
    localparam int CTL_LD_Q  = 1;   // Q <= inbus
    localparam int CTL_LD_M  = 2;   // M <= inbus
    localparam int CTL_QM1   = 3;   // reserved, held low
    localparam int CTL_SUB   = 4;   // adder computes A - M
    localparam int CTL_ASR   = 7;   // arithmetic shift right of {A,Q,Q-1}
    localparam int CTL_CNT   = 8;   // iteration counter increment
    localparam int CTL_OUT_A = 9;   // outbus = A
    localparam int CTL_OUT_Q = 10;  // outbus = Q

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD_M = 3'd2,
        S_LOAD_Q = 3'd3,
        S_EVAL   = 3'd4,
        S_SHIFT  = 3'd5,
        S_OUT_HI = 3'd6,
        S_OUT_LO = 3'd7
    } state_t;

endpackage

// File: rtl/booth_controller_ctl_enc.sv
// Purpose: combinational encoder from FSM state + handshake/Booth flags to the control word.
// Latency: zero cycles (pure decode). Backpressure: none; load bits follow in_valid.
// Ports: state (FSM state), in_valid, q0/q_1 (Booth pair), control (11-bit datapath word).
// Build macro BOOTH_FAST_SHIFT_EN: EVAL shifts directly when {q0,q_1} is 00 or 11.
module booth_ctl_enc
    import booth_pkg::*;
(
    input  logic [2:0]       state,
    input  logic             in_valid,
    input  logic             q0,
    input  logic             q_1,
    output logic [CTL_W-1:0] control
);

    always_comb begin
        control = '0;
        case (state_t'(state))
            S_LOAD_M: control[CTL_LD_M] = in_valid;
            S_LOAD_Q: control[CTL_LD_Q] = in_valid;
            S_EVAL: begin
                // 10 -> A-M, 01 -> A+M; the add never coincides with a shift
                if (q0 != q_1) begin
                    control[CTL_LD_A] = 1'b1;
                    control[CTL_SUB]  = q0;
                end
`ifdef BOOTH_FAST_SHIFT_EN
                else begin
                    control[CTL_ASR] = 1'b1;
                    control[CTL_CNT] = 1'b1;
                end
`endif
            end
            S_SHIFT: begin
                control[CTL_ASR] = 1'b1;
                control[CTL_CNT] = 1'b1;
            end
            S_OUT_HI: control[CTL_OUT_A] = 1'b1;
            S_OUT_LO: control[CTL_OUT_Q] = 1'b1;
            default:  control = '0;
        endcase
        control[CTL_QM1] = 1'b0;
    end

endmodule

// File: rtl/booth_controller.sv
// Purpose: sequencing FSM for the 8-bit radix-2 Booth datapath (clear, load M/Q, 8 iterations, 2-byte output).
// Latency: start->busy 1 cycle; Q accept -> out_valid 17 cycles (9..17 with BOOTH_FAST_SHIFT_EN).
// Backpressure: operand states hold while in_valid=0; OUT_HI/OUT_LO hold while out_ready=0.
// Ports: clk, reset (async, active-high), start/busy, in_valid/in_ready, q0/q_1/count from datapath,
//        control (11-bit control word), dp_rst (registered clear pulse), out_valid/out_last/out_ready.
module booth_controller
    import booth_pkg::*;
#(
    parameter int ITERS = 8      // 1..8, bounded by the 3-bit datapath counter
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             q0,
    input  logic             q_1,
    input  logic [2:0]       count,
    output logic [CTL_W-1:0] control,
    output logic             dp_rst,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    state_t state_q, state_d;
    logic   dp_rst_q, dp_rst_d;
    logic   last_iter;

    // count still holds the pre-increment value while the last shift is issued
    assign last_iter = (count == LAST_CNT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dp_rst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dp_rst_q <= dp_rst_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLR;
            S_CLR:    state_d = S_LOAD_M;
            S_LOAD_M: if (in_valid) state_d = S_LOAD_Q;
            S_LOAD_Q: if (in_valid) state_d = S_EVAL;
            S_EVAL: begin
`ifdef BOOTH_FAST_SHIFT_EN
                // no add needed: EVAL performs the shift itself
                if (q0 == q_1)
                    state_d = last_iter ? S_OUT_HI : S_EVAL;
                else
                    state_d = S_SHIFT;
`else
                state_d = S_SHIFT;
`endif
            end
            S_SHIFT:  state_d = last_iter ? S_OUT_HI : S_EVAL;
            S_OUT_HI: if (out_ready) state_d = S_OUT_LO;
            S_OUT_LO: if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Flop the clear so it is high exactly while the FSM sits in CLR
        dp_rst_d = (state_d == S_CLR);
    end

    // Moore output decode
    always_comb begin
        busy      = (state_q != S_IDLE);
        in_ready  = (state_q == S_LOAD_M) || (state_q == S_LOAD_Q);
        out_valid = (state_q == S_OUT_HI) || (state_q == S_OUT_LO);
        out_last  = (state_q == S_OUT_LO);
    end

    assign dp_rst = dp_rst_q;

    booth_ctl_enc u_ctl_enc (
        .state    (state_q),
        .in_valid (in_valid),
        .q0       (q0),
        .q_1      (q_1),
        .control  (control)
    );

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath closes the loop, a scoreboard
// queue holds expected output bytes and result latencies, and a negedge monitor checks them.
// Build macro BOOTH_FAST_SHIFT_EN selects the variable-latency expectations.
module tb_booth_controller;
    import booth_pkg::*;

`ifdef BOOTH_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, start, in_valid, out_ready;
    logic             busy, in_ready, dp_rst, out_valid, out_last;
    logic [CTL_W-1:0] control;
    logic             q0, q_1;
    logic [2:0]       count;
    logic [7:0]       inbus, outbus;

    // Datapath model; A carries a guard bit so products are exact for every M
    logic [8:0] a9;
    logic [7:0] m_r, q_r;
    logic       qm1;
    logic [2:0] cnt;
    logic       dp_clr;
    assign dp_clr = reset | dp_rst;

    always @(posedge clk or posedge dp_clr) begin
        if (dp_clr) begin
            a9 <= '0; m_r <= '0; q_r <= '0; qm1 <= 1'b0; cnt <= '0;
        end else begin
            if (control[CTL_LD_M]) m_r <= inbus;
            if (control[CTL_LD_Q]) q_r <= inbus;
            if (control[CTL_LD_A])
                a9 <= control[CTL_SUB] ? a9 - {m_r[7], m_r} : a9 + {m_r[7], m_r};
            if (control[CTL_ASR]) begin
                a9  <= {a9[8], a9[8:1]};
                q_r <= {a9[0], q_r[7:1]};
                qm1 <= q_r[0];
            end
            if (control[CTL_CNT]) cnt <= cnt + 3'd1;
        end
    end

    assign q0     = q_r[0];
    assign q_1    = qm1;
    assign count  = cnt;
    assign outbus = control[CTL_OUT_A] ? a9[7:0] : (control[CTL_OUT_Q] ? q_r : 8'h00);

    booth_controller #(.ITERS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q0        (q0),
        .q_1       (q_1),
        .count     (count),
        .control   (control),
        .dp_rst    (dp_rst),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    // Scoreboard: {byte, last} per output beat, and expected Q-accept-to-out_valid latency
    logic [8:0] exp_q[$];
    int         lat_q[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int acc_cyc;
        bit lat_pend;
        acc_cyc  = 0;
        lat_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lat_pend = 1'b0;
            end else begin
                if (control[CTL_LD_Q]) begin
                    acc_cyc  = cyc;
                    lat_pend = 1'b1;
                end
                if (out_valid) begin
                    if (lat_pend) begin
                        if (lat_q.size() == 0) fail("unexpected_result_latency");
                        else chk("result_latency", cyc - acc_cyc, lat_q.pop_front());
                        lat_pend = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        fail("unexpected_output_beat");
                    end else begin
                        chk("out_byte", {24'd0, outbus}, {24'd0, exp_q[0][8:1]});
                        chk("out_last", {31'd0, out_last}, {31'd0, exp_q[0][0]});
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One multiply; called #1 after a rising edge with the DUT idle.
    task automatic run_mul(input logic [7:0] m, input logic [7:0] q,
                           input logic [7:0] hi, input logic [7:0] lo,
                           input int lat, input int stall_in, input int stall_out,
                           input bit push);
        int k;
        if (push) begin
            exp_q.push_back({hi, 1'b0});
            exp_q.push_back({lo, 1'b1});
            lat_q.push_back(lat);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("dp_rst_in_clr", {31'd0, dp_rst}, 32'd1);
        @(posedge clk); #1;
        chk("dp_rst_single_cycle", {31'd0, dp_rst}, 32'd0);
        chk("in_ready_load_m", {31'd0, in_ready}, 32'd1);
        inbus = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (stall_in) begin @(posedge clk); #1; end
        chk("in_ready_load_q", {31'd0, in_ready}, 32'd1);
        inbus = q; in_valid = 1'b1; out_ready = (stall_out == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            if (stall_out > 0) begin
                k = 0;
                while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
                if (!out_valid) fail("out_valid_timeout");
                repeat (stall_out) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
            k = 0;
            while (busy && k < 60) begin @(posedge clk); #1; k++; end
            if (busy) fail("multiply_done_timeout");
        end
    endtask

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; inbus = 8'h00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'd0, out_last},  32'd0);
        chk("rst_dp_rst",    {31'd0, dp_rst},    32'd0);
        chk("rst_control",   {21'd0, control},   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 3 x 5, then back-to-back -1 x -1 and -128 x 1
        run_mul(8'h05, 8'h03, 8'h00, 8'h0F, FAST ? 11 : 17, 0, 0, 1'b1);
        run_mul(8'hFF, 8'hFF, 8'h00, 8'h01, FAST ? 10 : 17, 0, 0, 1'b1);
        run_mul(8'h80, 8'h01, 8'hFF, 8'h80, FAST ? 11 : 17, 0, 0, 1'b1);
        // operand stall of 5 cycles: 7 x -3
        run_mul(8'h07, 8'hFD, 8'hFF, 8'hEB, FAST ? 12 : 17, 5, 0, 1'b1);
        // output backpressure of 4 cycles in OUT_HI: 10 x 12
        run_mul(8'h0A, 8'h0C, 8'h00, 8'h78, FAST ? 11 : 17, 0, 4, 1'b1);

        // reset at the 4th shift of an aborted multiply
        run_mul(8'h11, 8'h55, 8'h00, 8'h00, 0, 0, 0, 1'b0);
        k = 0;
        while (!(control[CTL_ASR] && count == 3'd3) && k < 40) begin @(posedge clk); #1; k++; end
        if (!(control[CTL_ASR] && count == 3'd3)) fail("fourth_shift_timeout");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_out_last",  {31'd0, out_last},  32'd0);
        chk("abort_dp_rst",    {31'd0, dp_rst},    32'd0);
        chk("abort_control",   {21'd0, control},   32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        run_mul(8'h02, 8'h02, 8'h00, 8'h04, FAST ? 11 : 17, 0, 0, 1'b1);

        // latency extremes for the fast-shift build
        run_mul(8'h5A, 8'h00, 8'h00, 8'h00, FAST ? 9 : 17, 0, 0, 1'b1);
        run_mul(8'h03, 8'h55, 8'h00, 8'hFF, 17, 0, 0, 1'b1);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(posedge clk); #1; k++; end
        chk("scoreboard_bytes_left", exp_q.size(), 32'd0);
        chk("scoreboard_lat_left",   lat_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_controller.md
# booth_controller

Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath. It accepts two operand bytes (multiplicand, then multiplier) over a valid/ready input handshake. It drives the datapath's 11-bit control word through clear, load, add/subtract and shift steps for eight iterations, then streams the 16-bit product out as two bytes (A high, then Q low). It sits between the system operand source/result sink and the datapath; the datapath's `inbus` is fed directly by the operand source.

## Interface
- `ITERS`, 8: Booth iterations. Last iteration is detected when `count == ITERS-1`; must be ≤ 8 (3-bit datapath counter).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset; single clock domain.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `in_valid`  in  1  operand byte present on datapath `inbus`.
- `in_ready`  out  1  high in LOAD_M and LOAD_Q.
- `q0`  in  1  datapath Q[0].
- `q_1`  in  1  datapath Q-1.
- `count`  in  3  datapath iteration counter.
- `control`  out  11  datapath control word. Bits used: [0] A<=adder, [1] load Q, [2] load M, [4] subtract, [7] arithmetic shift right, [8] count++, [9] outbus=A, [10] outbus=Q. Bits [3], [5] and [6] are always 0.
- `dp_rst`  out  1  registered clear pulse, OR-ed with `reset` at top level into the datapath reset.
- `out_valid`  out  1  result byte valid on datapath `outbus`.
- `out_last`  out  1  marks the low (Q) byte.
- `out_ready`  in  1  sink accepts the byte.

## Operation
- States: IDLE, CLR, LOAD_M, LOAD_Q, EVAL, SHIFT, OUT_HI, OUT_LO.
- IDLE: `start`=1 → CLR. `start` in any other state is ignored.
- CLR: `dp_rst`=1 for exactly one cycle; clears A, Q, M, Q-1 and count. Next state is LOAD_M.
- LOAD_M: `control[2]` = `in_valid`. On `in_valid` → LOAD_Q; otherwise hold.
- LOAD_Q: `control[1]` = `in_valid`. On `in_valid` → EVAL.
- EVAL: action depends on {q0,q_1}:
  - 10: `control[0]`=1 and `control[4]`=1 (A−M).
  - 01: `control[0]`=1 and `control[4]`=0 (A+M).
  - 00/11: no write.
  - Next state is SHIFT.
- SHIFT: `control[7]`=1 and `control[8]`=1. If `count == ITERS-1` → OUT_HI, else → EVAL.
- Control-bit exclusivity: `control[0]` and `control[7]` are never asserted in the same cycle (shift would override the add).
- OUT_HI: `control[9]`=1, `out_valid`=1, `out_last`=0. On `out_ready` → OUT_LO.
- OUT_LO: `control[10]`=1, `out_valid`=1, `out_last`=1. On `out_ready` → IDLE.
- Arithmetic: the product is two's-complement {A,Q}. It is exact for all M except −128, where −M overflows; that case is documented and not flagged.

## Timing
- Reset values: state IDLE; `control`=0, `busy`=0, `in_ready`=0, `dp_rst`=0, `out_valid`=0, `out_last`=0.
- `control`, `in_ready`, `out_valid` and `out_last` are Moore decodes of the state register, qualified by `in_valid` where noted. `dp_rst` comes straight from a flop.
- `start` at cycle t → `busy` at t+1, CLR at t+1, LOAD_M at t+2.
- Q accepted at cycle t → EVAL/SHIFT occupy t+1..t+16 → `out_valid` at t+17 (fixed, without the configuration feature below).
- Backpressure: OUT_HI/OUT_LO hold with `outbus` stable for as long as `out_ready`=0. Operand states hold indefinitely while `in_valid`=0.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The datapath is cleared by the same `reset`.
- Back-to-back: `start` high in the cycle after the OUT_LO accept begins the next multiply.

## Configuration
- `BOOTH_FAST_SHIFT_EN`:
  - Defined: in EVAL with {q0,q_1} ∈ {00,11}, EVAL itself asserts `control[7]` and `control[8]`. The count check is applied there and SHIFT is skipped, so each iteration is 1 or 2 cycles and result latency is 9..17 cycles after Q accept.
  - Undefined: fixed 2-cycle iterations as above.

## Structure
- Shared package `booth_pkg` holds:
  - state enum;
  - control-bit index constants `CTL_LD_A`=0, `CTL_LD_Q`=1, `CTL_LD_M`=2, `CTL_QM1`=3, `CTL_SUB`=4, `CTL_ASR`=7, `CTL_CNT`=8, `CTL_OUT_A`=9, `CTL_OUT_Q`=10;
  - `CTL_W`=11 and `DATA_W`=8.
- One natural sub-module: `booth_ctl_enc`, a combinational state/flags-to-control-word encoder. The FSM and handshake live in the top.

## Test plan
- 3 × 5: bytes 0x05, 0x03 → out 0x00, then 0x0F with `out_last`; `out_valid` exactly 17 cycles after Q accept.
- −1 × −1: 0xFF, 0xFF → 0x00, 0x01. −128 × 1 (M=0x80, Q=0x01) → 0xFF, 0x80.
- Operand stall: `in_valid` low 5 cycles between bytes → FSM holds in LOAD_Q; product is unchanged (7 × −3 → 0xFF, 0xEB).
- Output backpressure: `out_ready` low 4 cycles in OUT_HI → `outbus`=A stable; `out_last` rises only after the first accept.
- Reset asserted at the 4th SHIFT → next cycle IDLE with all outputs 0; a following 2 × 2 yields 0x00, 0x04.
- With `BOOTH_FAST_SHIFT_EN`: Q=0x00 gives latency 9 cycles; Q=0x55 gives latency 17 cycles; both give correct products.
